// File: rtl/led_matrix_scan_ctrl_if.sv
// User-side port bundle of the LED matrix scan controller: frame-store writes,
// swap handshake and the row/column pins.
interface led_matrix_scan_ctrl_if;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_tick;
  logic [7:0] LEDrow;
  logic [7:0] LEDcol;

  modport master (
    output enable, wr_en, wr_row, wr_data, swap_req,
    input  swap_ack, frame_tick, LEDrow, LEDcol
  );

  modport slave (
    input  enable, wr_en, wr_row, wr_data, swap_req,
    output swap_ack, frame_tick, LEDrow, LEDcol
  );
endinterface

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan scheduler for an 8x8 LED matrix with a double-buffered frame store;
// shadow is committed to active only at a frame boundary or while idle.
module led_matrix_scan_ctrl #(
  parameter int NUM_ROWS     = 8,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  led_matrix_scan_ctrl_if.slave   bus
);
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [2:0]    LAST_ROW   = 3'(NUM_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_row, w_row_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [7:0][7:0] r_shadow, r_active;
  logic            r_pend;
  logic            r_tick, r_ack;
  logic [7:0]      r_ledrow, r_ledcol;
  logic            w_tick, w_commit, w_wr_ok;
  logic [7:0]      w_ledrow_nxt, w_ledcol_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_tick      = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = S_IDLE;
      w_row_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
          w_row_nxt   = '0;
          w_cnt_nxt   = '0;
        end
        S_BLANK: if (r_cnt == BLANK_LAST) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = '0;
        end
        S_DRIVE: if (r_cnt == DWELL_LAST) begin
          w_state_nxt = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
          w_cnt_nxt   = '0;
          if (r_row == LAST_ROW) begin
            w_row_nxt = '0;
            w_tick    = 1'b1;
          end else begin
            w_row_nxt = r_row + 3'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_row_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Commit at frame end, or on any cycle spent idle; shadow is sampled pre-write.
    w_commit = r_pend && (w_tick || (r_state == S_IDLE));

    w_ledrow_nxt = 8'hFF;
    w_ledcol_nxt = 8'h00;
    if (w_state_nxt == S_DRIVE) begin
      w_ledrow_nxt = ~(8'h01 << w_row_nxt);
      w_ledcol_nxt = w_commit ? r_shadow[w_row_nxt] : r_active[w_row_nxt];
    end
  end

  assign w_wr_ok = bus.wr_en && (32'(bus.wr_row) < NUM_ROWS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pend   <= 1'b0;
      r_tick   <= 1'b0;
      r_ack    <= 1'b0;
      r_ledrow <= 8'hFF;
      r_ledcol <= 8'h00;
    end else begin
      if (w_wr_ok) r_shadow[bus.wr_row] <= bus.wr_data;
      if (w_commit) r_active <= r_shadow;
      r_pend   <= bus.swap_req | (r_pend & ~w_commit);
      r_tick   <= w_tick;
      r_ack    <= w_commit;
      r_ledrow <= w_ledrow_nxt;
      r_ledcol <= w_ledcol_nxt;
    end
  end

  assign bus.LEDrow     = r_ledrow;
  assign bus.LEDcol     = r_ledcol;
  assign bus.frame_tick = r_tick;
  assign bus.swap_ack   = r_ack;
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl: scan-position reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_led_matrix_scan_ctrl;
  localparam int N = 4, D = 4, B = 2;
  localparam int PER = B + D, FRAME = N * PER;

  logic clk, rst;
  int   n_chk = 0, n_err = 0;

  led_matrix_scan_ctrl_if bus();

  led_matrix_scan_ctrl #(.NUM_ROWS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: scan position within the frame, plus both buffers and the pending flag.
  bit         m_valid = 0, m_run, m_pend;
  int         m_pos;
  logic [7:0] m_act[8], m_sh[8];
  logic [7:0] e_row, e_col;
  logic       e_ack, e_tick;

  always @(posedge clk) begin
    bit commit, tick;
    commit = 0;
    tick   = 0;
    if (rst) begin
      m_valid = 1; m_run = 0; m_pos = 0; m_pend = 0;
      for (int i = 0; i < 8; i++) begin m_act[i] = 8'h00; m_sh[i] = 8'h00; end
      e_row = 8'hFF; e_col = 8'h00; e_ack = 0; e_tick = 0;
    end else if (m_valid) begin
      if (!bus.enable) begin
        commit = m_pend && !m_run;
        m_run  = 0;
      end else if (!m_run) begin
        commit = m_pend;
        m_run  = 1;
        m_pos  = 0;
      end else begin
        m_pos++;
        if (m_pos == FRAME) begin m_pos = 0; tick = 1; commit = m_pend; end
      end
      if (commit) m_act = m_sh;
      if (bus.wr_en && bus.wr_row < N) m_sh[bus.wr_row] = bus.wr_data;
      m_pend = bus.swap_req || (m_pend && !commit);
      e_ack = commit; e_tick = tick; e_row = 8'hFF; e_col = 8'h00;
      if (m_run && (m_pos % PER) >= B) begin
        e_row = ~(8'h01 << (m_pos / PER));
        e_col = m_act[m_pos / PER];
      end
    end
  end

  always @(negedge clk) if (m_valid) begin
    chk("m_LEDrow", {24'd0, bus.LEDrow}, {24'd0, e_row});
    chk("m_LEDcol", {24'd0, bus.LEDcol}, {24'd0, e_col});
    chk("m_swap_ack", {31'd0, bus.swap_ack}, {31'd0, e_ack});
    chk("m_frame_tick", {31'd0, bus.frame_tick}, {31'd0, e_tick});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] r, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_row = r; bus.wr_data = d;
  endtask

  task automatic idle_in();
    bus.wr_en = 1'b0; bus.swap_req = 1'b0;
  endtask

  task automatic wait_ack();
    for (int k = 0; k < 60 && bus.swap_ack !== 1'b1; k++) step();
    chk("ack_wait", {31'd0, bus.swap_ack}, 32'd1);
  endtask

  // Called at frame position 0; walks one frame checking each driven row's column data.
  task automatic capture_frame(input logic [7:0] e0, e1, e2, e3);
    logic [7:0] e[4];
    logic [7:0] sel;
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < FRAME; k++) begin
      for (int r = 0; r < 4; r++) begin
        sel = ~(8'h01 << r);
        if (bus.LEDrow == sel) chk("frame_col", {24'd0, bus.LEDcol}, {24'd0, e[r]});
      end
      step();
    end
  endtask

  logic [7:0] seq1[24];

  initial begin
    rst = 1'b1; bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_row = '0;
    bus.wr_data = '0; bus.swap_req = 1'b0;
    seq1 = '{8'hFF,8'hFF,8'hFE,8'hFE,8'hFE,8'hFE, 8'hFF,8'hFF,8'hFD,8'hFD,8'hFD,8'hFD,
             8'hFF,8'hFF,8'hFB,8'hFB,8'hFB,8'hFB, 8'hFF,8'hFF,8'hF7,8'hF7,8'hF7,8'hF7};
    repeat (3) step();
    chk("rst_row", {24'd0, bus.LEDrow}, 32'hFF);
    chk("rst_col", {24'd0, bus.LEDcol}, 32'h00);
    chk("rst_ack_tick", {30'd0, bus.swap_ack, bus.frame_tick}, 32'd0);

    // 1: empty scan
    rst = 1'b0; bus.enable = 1'b1;
    step();
    for (int i = 0; i < FRAME; i++) begin
      chk("seq1_row", {24'd0, bus.LEDrow}, {24'd0, seq1[i]});
      chk("seq1_tick", {31'd0, bus.frame_tick}, 32'd0);
      step();
    end
    chk("seq1_tick_end", {31'd0, bus.frame_tick}, 32'd1);

    // 2: fill shadow, one swap
    wr(3'd0, 8'h81); step(); wr(3'd1, 8'h42); step();
    wr(3'd2, 8'h24); step(); wr(3'd3, 8'h18); step();
    idle_in(); bus.swap_req = 1'b1; step(); idle_in();
    wait_ack();
    chk("ack_with_tick", {31'd0, bus.frame_tick}, 32'd1);
    capture_frame(8'h81, 8'h42, 8'h24, 8'h18);

    // 3: write row 1 on the commit edge
    bus.swap_req = 1'b1; step(); idle_in();
    repeat (FRAME - 2) step();
    wr(3'd1, 8'hFF); step(); idle_in();
    chk("commit_ack", {31'd0, bus.swap_ack}, 32'd1);
    capture_frame(8'h81, 8'h42, 8'h24, 8'h18);
    bus.swap_req = 1'b1; step(); idle_in();
    wait_ack();
    capture_frame(8'h81, 8'hFF, 8'h24, 8'h18);

    // 4: out-of-range row write
    wr(3'd5, 8'hAA); bus.swap_req = 1'b1; step(); idle_in();
    wait_ack();
    capture_frame(8'h81, 8'hFF, 8'h24, 8'h18);

    // 5: drop enable mid-drive of row 2 with swap pending
    wr(3'd0, 8'h3C); bus.swap_req = 1'b1; step(); idle_in();
    repeat (14) step();
    chk("row2_drive", {24'd0, bus.LEDrow}, 32'hFB);
    bus.enable = 1'b0; step();
    chk("dis_row", {24'd0, bus.LEDrow}, 32'hFF);
    chk("dis_col", {24'd0, bus.LEDcol}, 32'h00);
    chk("dis_ack_tick", {30'd0, bus.swap_ack, bus.frame_tick}, 32'd0);
    step();
    chk("idle_ack", {31'd0, bus.swap_ack}, 32'd1);
    step();
    bus.enable = 1'b1; step();
    chk("re_en_blank", {24'd0, bus.LEDrow}, 32'hFF);
    step(); step();
    chk("re_en_row0", {24'd0, bus.LEDrow}, 32'hFE);
    chk("re_en_col0", {24'd0, bus.LEDcol}, 32'h3C);

    // 6: reset mid-frame
    repeat (10) step();
    rst = 1'b1; step();
    chk("rst2_row", {24'd0, bus.LEDrow}, 32'hFF);
    chk("rst2_col_ack_tick", {22'd0, bus.LEDcol, bus.swap_ack, bus.frame_tick}, 32'd0);
    rst = 1'b0; step();
    capture_frame(8'h00, 8'h00, 8'h00, 8'h00);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.enable   = ($urandom_range(0, 99) != 0);
      bus.wr_en    = ($urandom_range(0, 2) == 0);
      bus.wr_row   = 3'($urandom_range(0, 7));
      bus.wr_data  = 8'($urandom_range(0, 255));
      bus.swap_req = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; idle_in();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
